// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: free-running VGA raw-sync timing source with a frame-synchronous
// test-pattern generator. Raw syncs are high over the active region; porches are added downstream.
// Optional moving-bar sweep (pattern 7) is built only when VGA_PATTERN_SWEEP_EN is defined.
module vga_pattern_gen #(
  parameter int VIDEO_WIDTH = 3,
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2:0]             pattern,
  output logic                   ohsync,
  output logic                   ovsync,
  output logic [VIDEO_WIDTH-1:0] oredv,
  output logic [VIDEO_WIDTH-1:0] ogrnv,
  output logic [VIDEO_WIDTH-1:0] obluv
);

  localparam logic [9:0] LAST_COL = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] LAST_ROW = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] ACT_COLS = 10'(ACTIVE_COLS);
  localparam logic [9:0] ACT_ROWS = 10'(ACTIVE_ROWS);
  localparam logic [9:0] LAST_ACT_COL = 10'(ACTIVE_COLS - 1);
  localparam logic [9:0] LAST_ACT_ROW = 10'(ACTIVE_ROWS - 1);
  localparam int BAR_W = ACTIVE_COLS / 8;

  typedef enum logic [2:0] {
    PAT_BLACK   = 3'd0,
    PAT_RED     = 3'd1,
    PAT_GREEN   = 3'd2,
    PAT_BLUE    = 3'd3,
    PAT_CHECKER = 3'd4,
    PAT_BARS    = 3'd5,
    PAT_BORDER  = 3'd6,
    PAT_SWEEP   = 3'd7
  } pat_e;

  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  pat_e       curPat_q, curPat_d;
  logic       frameEnd;
  logic       active;
  logic       onBorder;
  logic [2:0] barIdx;
  logic [2:0] rgbOn;
  logic       hsync_q, vsync_q;
  logic [VIDEO_WIDTH-1:0] red_q, grn_q, blu_q;

`ifdef VGA_PATTERN_SWEEP_EN
  logic [9:0]  barX_q, barX_d;
  logic [10:0] barStep;
  logic [10:0] barEnd;
  logic        inBar;
`endif

  // Next raster position: column wraps each line, row advances on the column wrap.
  always_comb begin
    frameEnd = (col_q == LAST_COL) && (row_q == LAST_ROW);
    col_d    = (col_q == LAST_COL) ? 10'd0 : col_q + 10'd1;
    row_d    = row_q;
    if (col_q == LAST_COL) begin
      row_d = (row_q == LAST_ROW) ? 10'd0 : row_q + 10'd1;
    end
    curPat_d = frameEnd ? pat_e'(pattern) : curPat_q;
  end

`ifdef VGA_PATTERN_SWEEP_EN
  // Sweep bar position steps by 4 columns per frame and restarts once it would leave the active width.
  always_comb begin
    barStep = {1'b0, barX_q} + 11'd4;
    barEnd  = {1'b0, barX_q} + 11'd16;
    inBar   = (col_q >= barX_q) && ({1'b0, col_q} < barEnd);
    barX_d  = barX_q;
    if (frameEnd) begin
      barX_d = (barStep >= 11'(ACTIVE_COLS)) ? 10'd0 : barStep[9:0];
    end
  end
`endif

  // Colour-bar index from constant column thresholds, avoiding a divider.
  always_comb begin
    barIdx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (col_q >= 10'(i * BAR_W)) begin
        barIdx = 3'(i);
      end
    end
  end

  // Per-channel on/off for the current pixel; everything outside the active region is black.
  always_comb begin
    active   = (col_q < ACT_COLS) && (row_q < ACT_ROWS);
    onBorder = (col_q == 10'd0) || (col_q == LAST_ACT_COL) ||
               (row_q == 10'd0) || (row_q == LAST_ACT_ROW);
    rgbOn    = 3'b000;
    if (active) begin
      case (curPat_q)
        PAT_RED:     rgbOn = 3'b100;
        PAT_GREEN:   rgbOn = 3'b010;
        PAT_BLUE:    rgbOn = 3'b001;
        PAT_CHECKER: rgbOn = {3{col_q[5] ^ row_q[5]}};
        PAT_BARS:    rgbOn = 3'd7 - barIdx;
        PAT_BORDER:  rgbOn = onBorder ? 3'b111 : 3'b000;
`ifdef VGA_PATTERN_SWEEP_EN
        PAT_SWEEP:   rgbOn = inBar ? 3'b111 : 3'b000;
`else
        PAT_SWEEP:   rgbOn = 3'b000;
`endif
        default:     rgbOn = 3'b000;
      endcase
    end
  end

  // Raster counters and frame-latched pattern; reset restarts the frame at (0,0) with pattern 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q    <= 10'd0;
      row_q    <= 10'd0;
      curPat_q <= PAT_BLACK;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      curPat_q <= curPat_d;
    end
  end

`ifdef VGA_PATTERN_SWEEP_EN
  // Sweep bar position register, only present when the sweep is built.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      barX_q <= 10'd0;
    end else begin
      barX_q <= barX_d;
    end
  end
`endif

  // Registered syncs and video share one pipeline stage so they stay aligned.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      red_q   <= '0;
      grn_q   <= '0;
      blu_q   <= '0;
    end else begin
      hsync_q <= (col_q < ACT_COLS);
      vsync_q <= (row_q < ACT_ROWS);
      red_q   <= {VIDEO_WIDTH{rgbOn[2]}};
      grn_q   <= {VIDEO_WIDTH{rgbOn[1]}};
      blu_q   <= {VIDEO_WIDTH{rgbOn[0]}};
    end
  end

  assign ohsync = hsync_q;
  assign ovsync = vsync_q;
  assign oredv  = red_q;
  assign ogrnv  = grn_q;
  assign obluv  = blu_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: drives vga_pattern_gen on a shrunken raster and compares every output
// cycle against a reference model computed from cycle count, frame number and pixel arithmetic.
// Sweep expectations follow VGA_PATTERN_SWEEP_EN when it is defined for the build.
module tb_vga_pattern_gen;

  localparam int VW = 3;
  localparam int TC = 56;
  localparam int TR = 40;
  localparam int AC = 48;
  localparam int AR = 36;
  localparam int FRAME = TC * TR;

  logic          clock = 1'b0;
  logic          reset;
  logic [2:0]    pattern;
  logic          ohsync, ovsync;
  logic [VW-1:0] oredv, ogrnv, obluv;

  int     checks   = 0;
  int     failures = 0;
  longint t;
  int     framePat [64];

  vga_pattern_gen #(
    .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
    .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR)
  ) dut (
    .clock(clock), .reset(reset), .pattern(pattern),
    .ohsync(ohsync), .ovsync(ovsync),
    .oredv(oredv), .ogrnv(ogrnv), .obluv(obluv)
  );

  always #5 clock = ~clock;

  // Reference pixel: {hsync, vsync, R, G, B} from raster position, pattern and sweep position.
  function automatic logic [10:0] expPix(input int col, input int row, input int pat, input int barx);
    int  r, g, b, c;
    bit  hs, vs;
    hs = (col < AC);
    vs = (row < AR);
    r = 0; g = 0; b = 0;
    if (hs && vs) begin
      case (pat)
        1: r = 7;
        2: g = 7;
        3: b = 7;
        4: if (((col / 32) + (row / 32)) % 2 == 1) begin r = 7; g = 7; b = 7; end
        5: begin
          c = 7 - col / (AC / 8);
          r = ((c / 4) % 2) * 7;
          g = ((c / 2) % 2) * 7;
          b = (c % 2) * 7;
        end
        6: if (col == 0 || col == AC - 1 || row == 0 || row == AR - 1) begin r = 7; g = 7; b = 7; end
        7: begin
`ifdef VGA_PATTERN_SWEEP_EN
          if (col >= barx && col < barx + 16) begin r = 7; g = 7; b = 7; end
`endif
        end
        default: ;
      endcase
    end
    return {hs, vs, 3'(r), 3'(g), 3'(b)};
  endfunction

  task automatic checkOutput(input string tag, input logic [10:0] expv);
    logic [10:0] obs;
    obs = {ohsync, ovsync, oredv, ogrnv, obluv};
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // One clock: drive pattern, predict the pixel for the pre-edge position, then check after the edge.
  task automatic applyStimulus(input logic [2:0] p);
    int col, row, frame;
    logic [10:0] e;
    pattern = p;
    col   = int'(t % TC);
    row   = int'((t / TC) % TR);
    frame = int'(t / FRAME);
    e = expPix(col, row, framePat[frame % 64], 4 * (frame % ((AC + 3) / 4)));
    if (col == TC - 1 && row == TR - 1) framePat[(frame + 1) % 64] = int'(p);
    @(posedge clock);
    #1;
    t++;
    checkOutput($sformatf("pix(%0d,%0d)f%0d", col, row, frame), e);
  endtask

  // One full frame; the pattern input switches from a to b at the given row.
  task automatic runFrame(input logic [2:0] a, input logic [2:0] b, input int switchRow);
    for (int c = 0; c < FRAME; c++) begin
      applyStimulus((c / TC < switchRow) ? a : b);
    end
  endtask

  initial begin
    reset   = 1'b1;
    pattern = 3'd0;
    t       = 0;
    for (int i = 0; i < 64; i++) framePat[i] = 0;
    #12;
    checkOutput("resetHeld", 11'd0);
    @(posedge clock);
    #1;
    checkOutput("resetHeldEdge", 11'd0);
    reset = 1'b0;

    runFrame(3'd0, 3'd0, 0);
    runFrame(3'd5, 3'd5, 0);
    runFrame(3'd4, 3'd4, 0);
    runFrame(3'd4, 3'd1, 20);
    runFrame(3'd6, 3'd6, 0);
    runFrame(3'd7, 3'd7, 0);
    for (int f = 0; f < 5; f++) begin
      runFrame(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), int'($urandom_range(1, TR - 1)));
    end

    for (int c = 0; c < 20 * TC + 30; c++) begin
      applyStimulus(3'($urandom_range(0, 7)));
    end
    #3;
    reset = 1'b1;
    #1;
    checkOutput("asyncReset", 11'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("resetHold%0d", k), 11'd0);
    end
    reset = 1'b0;
    t = 0;
    for (int i = 0; i < 64; i++) framePat[i] = 0;
    applyStimulus(3'd3);
    checkOutput("firstAfterReset", {1'b1, 1'b1, 9'd0});

    for (int f = 0; f < 13; f++) begin
      runFrame(3'd7, 3'd7, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
